// File: rtl/alarm_movement_pkg.sv
// Shared constants and move decoding for alarm_movement.
package alarm_movement_pkg;

  localparam int ALARM_DLY_DEF = 3;
  localparam int POS_W_DEF     = 3;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    MOVE_NONE,
    MOVE_LEFT,
    MOVE_RIGHT
  } move_e;

  // Simultaneous left and right requests cancel out.
  function automatic move_e decode_move(input logic left, input logic right);
    if (left && !right) return MOVE_LEFT;
    if (right && !left) return MOVE_RIGHT;
    return MOVE_NONE;
  endfunction

endpackage

// File: rtl/alarm_movement_rise_detect.sv
// Rising-edge detector; ignores a level already high on the first edge after reset.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic prev;
  logic armed;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= d;
      armed <= 1'b1;
    end
  end

  // armed blocks the first post-reset edge, so only a 0->1 seen after release counts.
  assign pulse = armed & d & ~prev;

endmodule

// File: rtl/alarm_movement.sv
// Debounced alarm counter plus left/right position tracker.
// Define ALARM_MOVEMENT_WRAP_EN to make the position wrap instead of saturate.
module alarm_movement
  import alarm_movement_pkg::*;
#(
  parameter int ALARM_DLY = ALARM_DLY_DEF,
  parameter int POS_W     = POS_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             l_in,
  input  logic             r_in,
  output logic             y,
  output logic [POS_W-1:0] state_out
);

  localparam logic [CNT_W-1:0] DLY     = CNT_W'(ALARM_DLY);
  localparam logic [POS_W-1:0] POS_MAX = {POS_W{1'b1}};
  localparam logic [POS_W-1:0] POS_RST = POS_W'(1) << (POS_W - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [POS_W-1:0] pos_next;
  logic             l_evt;
  logic             r_evt;
  move_e            move;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cnt_next = '0;
    if (a) cnt_next = (cnt == DLY) ? cnt : cnt + 1'b1;
  end

  // y is registered from the next-count compare so it tracks cnt without lag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      y   <= 1'b0;
    end else begin
      cnt <= cnt_next;
      y   <= (cnt_next == DLY);
    end
  end

  rise_detect u_left (
    .clk   (clk),
    .reset (reset),
    .d     (l_in),
    .pulse (l_evt)
  );

  rise_detect u_right (
    .clk   (clk),
    .reset (reset),
    .d     (r_in),
    .pulse (r_evt)
  );

  assign move = decode_move(l_evt, r_evt);

  always_comb begin
    pos_next = state_out;
    unique case (move)
      MOVE_LEFT: begin
`ifdef ALARM_MOVEMENT_WRAP_EN
        pos_next = state_out - 1'b1;
`else
        pos_next = (state_out == '0) ? state_out : state_out - 1'b1;
`endif
      end
      MOVE_RIGHT: begin
`ifdef ALARM_MOVEMENT_WRAP_EN
        pos_next = state_out + 1'b1;
`else
        pos_next = (state_out == POS_MAX) ? state_out : state_out + 1'b1;
`endif
      end
      default: pos_next = state_out;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_out <= POS_RST;
    else        state_out <= pos_next;
  end

endmodule

// File: tb/tb_alarm_movement.sv
// Directed, table-driven bench for alarm_movement (default parameters).
module tb_alarm_movement;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a = 1'b0;
  logic       l_in = 1'b0;
  logic       r_in = 1'b0;
  logic       y;
  logic [2:0] state_out;

  int tests = 0;
  int fails = 0;

`ifdef ALARM_MOVEMENT_WRAP_EN
  localparam logic [2:0] LO_END = 3'd7;
  localparam logic [2:0] HI_END = 3'd0;
`else
  localparam logic [2:0] LO_END = 3'd0;
  localparam logic [2:0] HI_END = 3'd7;
`endif

  typedef struct {
    logic       rst;
    logic       a;
    logic       l;
    logic       r;
    logic       y;
    logic [2:0] pos;
  } vec_t;

  vec_t vecs[$];

  alarm_movement dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .l_in      (l_in),
    .r_in      (r_in),
    .y         (y),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reset asserted in the low phase; outputs checked before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_y", {7'd0, y}, 8'd0);
    check("reset_pos", {5'd0, state_out}, 8'd4);
    #1;
    reset = 1'b1;
  endtask

  task automatic step(input logic sa, input logic sl, input logic sr,
                      input logic ey, input logic [2:0] epos, input string name);
    @(negedge clk);
    a    = sa;
    l_in = sl;
    r_in = sr;
    @(posedge clk);
    #1;
    check({name, "_y"}, {7'd0, y}, {7'd0, ey});
    check({name, "_pos"}, {5'd0, state_out}, {5'd0, epos});
  endtask

  task automatic add(input logic rst, input logic va, input logic vl, input logic vr,
                     input logic vy, input logic [2:0] vpos);
    vecs.push_back('{rst, va, vl, vr, vy, vpos});
  endtask

  initial begin
    // Alarm: held high, drop, then a too-short pulse.
    add(1, 0, 0, 0, 0, 4);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, (i >= 2), 4);
    add(0, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 0, 4);
    add(0, 1, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 4);
    add(0, 0, 0, 0, 0, 4);

    // Left pulses down to the lower boundary.
    add(1, 0, 0, 0, 0, 4);
    for (int i = 0; i < 4; i++) begin
      add(0, 0, 1, 0, 0, 3'(3 - i));
      add(0, 0, 0, 0, 0, 3'(3 - i));
    end
    add(0, 0, 1, 0, 0, LO_END);
    add(0, 0, 0, 0, 0, LO_END);

    // From 0, right pulses up to the upper boundary.
    add(1, 0, 0, 0, 0, 4);
    for (int i = 0; i < 4; i++) begin
      add(0, 0, 1, 0, 0, 3'(3 - i));
      add(0, 0, 0, 0, 0, 3'(3 - i));
    end
    for (int i = 1; i <= 7; i++) begin
      add(0, 0, 0, 1, 0, 3'(i));
      add(0, 0, 0, 0, 0, 3'(i));
    end
    add(0, 0, 0, 1, 0, HI_END);
    add(0, 0, 0, 0, 0, HI_END);

    // Simultaneous events cancel; a held level yields one event; alarm is independent.
    add(1, 0, 0, 0, 0, 4);
    add(0, 0, 1, 1, 0, 4);
    add(0, 0, 0, 0, 0, 4);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 0, (i >= 2), 3);
    add(0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 1, 0, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        a    = vecs[i].a;
        l_in = vecs[i].l;
        r_in = vecs[i].r;
        do_reset();
      end else begin
        step(vecs[i].a, vecs[i].l, vecs[i].r, vecs[i].y, vecs[i].pos, $sformatf("vec%0d", i));
      end
    end

    // Asynchronous reset mid-operation with cnt=2 and state_out=6.
    a = 1'b0; l_in = 1'b0; r_in = 1'b0;
    do_reset();
    step(0, 0, 1, 0, 5, "mid_r1");
    step(0, 0, 0, 0, 5, "mid_idle");
    step(0, 0, 1, 0, 6, "mid_r2");
    step(1, 0, 0, 0, 6, "mid_a1");
    step(1, 0, 0, 0, 6, "mid_a2");
    #2;
    reset = 1'b0;
    #1;
    check("async_y", {7'd0, y}, 8'd0);
    check("async_pos", {5'd0, state_out}, 8'd4);
    reset = 1'b1;
    step(1, 0, 0, 0, 4, "restart1");
    step(1, 0, 0, 0, 4, "restart2");
    step(1, 0, 0, 1, 4, "restart3");

    // Level already high at reset release must not count as an event.
    a = 1'b0; l_in = 1'b1; r_in = 1'b0;
    do_reset();
    step(0, 1, 0, 0, 4, "hold_l1");
    step(0, 1, 0, 0, 4, "hold_l2");
    step(0, 0, 0, 0, 4, "hold_drop");
    step(0, 1, 0, 0, 3, "hold_rise");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
